// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the CPU/DMA memory bus arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        D_IDLE,
        D_ISSUED,
        D_ACK
    } dma_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } bus_owner_t;

    // Starve counter width: enough to hold the limit itself, never below one bit.
    function automatic int starve_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating up-counter with synchronous clear and a reached-limit flag.
// Counts consecutive CPU wins while a DMA request is waiting.
module arb_starve_ctr #(
    parameter int LIMIT = 4,
    parameter int W     = 3
) (
    input  logic         ph1,
    input  logic         resetb,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_limit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    // Saturation means the count never passes LIM, so equality is the limit test;
    // with LIMIT=0 the count stays at zero and the flag is permanently set.
    assign at_limit = (count == LIM);

    // Clear wins over increment; hold once saturated.
    always_ff @(posedge ph1 or negedge resetb) begin
        if (!resetb) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory arbiter between the CPU core and a DMA/debug requester.
// One access per cycle, fixed read latency of one cycle, read data routed back
// to whichever requester issued it. DMA progress is bounded by MAX_STARVE.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_STARVE = 4
) (
    input  logic              ph1,
    input  logic              resetb,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dma_owner
);

    localparam int SW = starve_w(MAX_STARVE);

    dma_state_t        dstate, dstate_nxt;
    logic              dma_cand, dma_grant, cpu_grant;
    logic              starve_lim;
    logic [SW-1:0]     starve;
    logic              rd_pend;
    bus_owner_t        own_q;
    logic [DATA_W-1:0] dma_rdata_q;

    // Per-cycle grant: DMA only when idle, and only if the CPU is quiet or has
    // used up its allowance of consecutive wins. Everything is forced low in reset.
    always_comb begin
        dma_cand  = resetb & dma_req & (dstate == D_IDLE);
        dma_grant = dma_cand & (!cpu_req | starve_lim);
        cpu_grant = resetb & cpu_req & !dma_grant;
    end

    assign cpu_ready = cpu_grant;

    // Bus mux: drive memory from whichever requester won; idle bus is all zero.
    always_comb begin
        mem_en    = dma_grant | cpu_grant;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dma_grant) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (cpu_grant) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    arb_starve_ctr #(
        .LIMIT (MAX_STARVE),
        .W     (SW)
    ) u_starve (
        .ph1      (ph1),
        .resetb   (resetb),
        .clr      (dma_grant | !dma_cand),
        .inc      (dma_cand & cpu_grant),
        .count    (starve),
        .at_limit (starve_lim)
    );

    // DMA state register.
    always_ff @(posedge ph1 or negedge resetb) begin
        if (!resetb) dstate <= D_IDLE;
        else         dstate <= dstate_nxt;
    end

    // DMA sequencing: issue once, wait out the read latency, ack, then re-arm.
    always_comb begin
        dstate_nxt = dstate;
        case (dstate)
            D_IDLE:   if (dma_grant) dstate_nxt = D_ISSUED;
            D_ISSUED: dstate_nxt = D_ACK;
            D_ACK:    dstate_nxt = D_IDLE;
            default:  dstate_nxt = D_IDLE;
        endcase
    end

    // Remember who issued this cycle's access and whether it was a read, so the
    // returning data next cycle can be steered to its owner.
    always_ff @(posedge ph1 or negedge resetb) begin
        if (!resetb) begin
            rd_pend <= 1'b0;
            own_q   <= OWN_CPU;
        end else begin
            rd_pend <= mem_en & !mem_we;
            own_q   <= dma_grant ? OWN_DMA : OWN_CPU;
        end
    end

    // Capture DMA read data while it is on the bus so it is stable during the ack.
    always_ff @(posedge ph1 or negedge resetb) begin
        if (!resetb) begin
            dma_rdata_q <= '0;
        end else if (dstate == D_ISSUED && rd_pend && own_q == OWN_DMA) begin
            dma_rdata_q <= mem_rdata;
        end
    end

    assign dma_owner  = (own_q == OWN_DMA);
    assign dma_ack    = (dstate == D_ACK);
    assign dma_rdata  = dma_rdata_q;
    assign cpu_rvalid = rd_pend & (own_q == OWN_CPU);
    // CPU read data flows straight from memory; no extra latency on the CPU path.
    assign cpu_rdata  = resetb ? mem_rdata : '0;

    // The DMA requester must hold its request until it has seen the ack.
    a_dma_req_held: assert property (
        @(posedge ph1) disable iff (!resetb) (dstate != D_IDLE) |-> dma_req
    ) else $error("dma_req dropped before dma_ack");

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: default instance with a small memory
// model, plus a MAX_STARVE=0 instance for the DMA-always-wins case.
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    logic        ph1, resetb;
    logic        cpu_req, cpu_we, cpu_ready, cpu_rvalid;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_ack;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic        mem_en, mem_we, dma_owner;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic        cpu_req0, cpu_we0, cpu_ready0, cpu_rvalid0;
    logic [15:0] cpu_addr0;
    logic [7:0]  cpu_wdata0, cpu_rdata0;
    logic        dma_req0, dma_we0, dma_ack0;
    logic [15:0] dma_addr0;
    logic [7:0]  dma_wdata0, dma_rdata0;
    logic        mem_en0, mem_we0, dma_owner0;
    logic [15:0] mem_addr0;
    logic [7:0]  mem_wdata0, mem_rdata0;

    logic [7:0]  mem [256];

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.MAX_STARVE(4)) dut (
        .ph1(ph1), .resetb(resetb),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dma_owner(dma_owner)
    );

    mem_bus_arbiter #(.MAX_STARVE(0)) dut0 (
        .ph1(ph1), .resetb(resetb),
        .cpu_req(cpu_req0), .cpu_we(cpu_we0), .cpu_addr(cpu_addr0), .cpu_wdata(cpu_wdata0),
        .cpu_ready(cpu_ready0), .cpu_rvalid(cpu_rvalid0), .cpu_rdata(cpu_rdata0),
        .dma_req(dma_req0), .dma_we(dma_we0), .dma_addr(dma_addr0), .dma_wdata(dma_wdata0),
        .dma_ack(dma_ack0), .dma_rdata(dma_rdata0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0), .dma_owner(dma_owner0)
    );

    initial begin
        ph1 = 1'b0;
        forever #5 ph1 = ~ph1;
    end

    // Memory model: one-cycle read latency; reset preloads $15 = $7F.
    always @(posedge ph1 or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h15] <= 8'h7F;
            mem_rdata  <= 8'h00;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge ph1);
        #1;
    endtask

    initial begin
        resetb = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0015; cpu_wdata = 8'h00;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'h00;
        cpu_req0 = 1'b0; cpu_we0 = 1'b0; cpu_addr0 = 16'h0000; cpu_wdata0 = 8'h00;
        dma_req0 = 1'b0; dma_we0 = 1'b0; dma_addr0 = 16'h0000; dma_wdata0 = 8'h00;
        mem_rdata0 = 8'h00;

        // Reset state; cpu_req is high to show the comb outputs are held off.
        @(negedge ph1);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'(0));
        chk("rst_mem_en",    32'(mem_en),    32'(0));
        chk("rst_cpu_rvalid",32'(cpu_rvalid),32'(0));
        chk("rst_dma_ack",   32'(dma_ack),   32'(0));
        chk("rst_dma_owner", 32'(dma_owner), 32'(0));
        chk("rst_dma_rdata", 32'(dma_rdata), 32'(0));
        tick;
        resetb = 1'b1;

        // CPU read $0015 alone.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0015;
        @(negedge ph1);
        chk("cpurd_ready",   32'(cpu_ready), 32'(1));
        chk("cpurd_mem_en",  32'(mem_en),    32'(1));
        chk("cpurd_addr",    32'(mem_addr),  32'h0015);
        chk("cpurd_we",      32'(mem_we),    32'(0));
        tick;
        cpu_req = 1'b0;
        @(negedge ph1);
        chk("cpurd_rvalid",  32'(cpu_rvalid), 32'(1));
        chk("cpurd_rdata",   32'(cpu_rdata),  32'h7F);
        chk("cpurd_owner",   32'(dma_owner),  32'(0));
        chk("cpurd_idle",    32'(mem_en),     32'(0));
        tick;
        @(negedge ph1);
        chk("cpurd_rvalid_off", 32'(cpu_rvalid), 32'(0));
        tick;

        // DMA read $0015 alone: issue, wait, ack with data, no re-issue.
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0015;
        @(negedge ph1);
        chk("dmard_mem_en",  32'(mem_en),   32'(1));
        chk("dmard_addr",    32'(mem_addr), 32'h0015);
        chk("dmard_noack0",  32'(dma_ack),  32'(0));
        tick;
        @(negedge ph1);
        chk("dmard_noreiss1",32'(mem_en),    32'(0));
        chk("dmard_noack1",  32'(dma_ack),   32'(0));
        chk("dmard_owner",   32'(dma_owner), 32'(1));
        chk("dmard_norvalid",32'(cpu_rvalid),32'(0));
        tick;
        @(negedge ph1);
        chk("dmard_ack",     32'(dma_ack),   32'(1));
        chk("dmard_rdata",   32'(dma_rdata), 32'h7F);
        chk("dmard_noreiss2",32'(mem_en),    32'(0));
        tick;
        dma_req = 1'b0;
        @(negedge ph1);
        chk("dmard_ack_off", 32'(dma_ack), 32'(0));
        tick;

        // Starvation bound: four CPU wins, DMA on the fifth cycle.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0030;
        for (int i = 0; i < 4; i++) begin
            @(negedge ph1);
            chk($sformatf("stv_cpu%0d", i), 32'(cpu_ready), 32'(1));
            chk($sformatf("stv_addr%0d", i), 32'(mem_addr), 32'h0020);
            if (i > 0) chk($sformatf("stv_rv%0d", i), 32'(cpu_rvalid), 32'(1));
            tick;
        end
        @(negedge ph1);
        chk("stv_cpu_stall", 32'(cpu_ready), 32'(0));
        chk("stv_dma_addr",  32'(mem_addr),  32'h0030);
        chk("stv_rv4",       32'(cpu_rvalid),32'(1));
        chk("stv_cnt_sat",   32'(dut.starve),32'(4));
        tick;
        @(negedge ph1);
        chk("stv_cpu_resume",32'(cpu_ready), 32'(1));
        chk("stv_rv_gap",    32'(cpu_rvalid),32'(0));
        chk("stv_cnt_clr",   32'(dut.starve),32'(0));
        tick;
        @(negedge ph1);
        chk("stv_ack",       32'(dma_ack),   32'(1));
        chk("stv_cpu_w_ack", 32'(cpu_ready), 32'(1));
        tick;
        cpu_req = 1'b0; dma_req = 1'b0;
        @(negedge ph1);
        chk("stv_idle",      32'(mem_en), 32'(0));
        tick;

        // CPU write $15=$00, DMA write $15=$7F, CPU read back.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0015; cpu_wdata = 8'h00;
        @(negedge ph1);
        chk("cpuwr_we",      32'(mem_we),    32'(1));
        chk("cpuwr_wdata",   32'(mem_wdata), 32'h00);
        tick;
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge ph1);
        chk("cpuwr_norv",    32'(cpu_rvalid), 32'(0));
        tick;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0015; dma_wdata = 8'h7F;
        @(negedge ph1);
        chk("dmawr_we",      32'(mem_we),    32'(1));
        chk("dmawr_wdata",   32'(mem_wdata), 32'h7F);
        tick;
        tick;
        @(negedge ph1);
        chk("dmawr_ack",     32'(dma_ack), 32'(1));
        tick;
        dma_req = 1'b0; dma_we = 1'b0;
        cpu_req = 1'b1; cpu_addr = 16'h0015;
        @(negedge ph1);
        chk("rdbk_ready",    32'(cpu_ready), 32'(1));
        tick;
        cpu_req = 1'b0;
        @(negedge ph1);
        chk("rdbk_rvalid",   32'(cpu_rvalid), 32'(1));
        chk("rdbk_rdata",    32'(cpu_rdata),  32'h7F);
        tick;

        // Reset while the DMA read is in D_ISSUED: access dropped, no ack.
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0015;
        tick;
        resetb = 1'b0; dma_req = 1'b0; cpu_req = 1'b1;
        @(negedge ph1);
        chk("mrst_ack",      32'(dma_ack),   32'(0));
        chk("mrst_mem_en",   32'(mem_en),    32'(0));
        chk("mrst_ready",    32'(cpu_ready), 32'(0));
        chk("mrst_owner",    32'(dma_owner), 32'(0));
        chk("mrst_rdata",    32'(dma_rdata), 32'(0));
        chk("mrst_rvalid",   32'(cpu_rvalid),32'(0));
        tick;
        @(negedge ph1);
        chk("mrst_ack2",     32'(dma_ack), 32'(0));
        tick;
        resetb = 1'b1; cpu_req = 1'b0;
        @(negedge ph1);
        chk("mrst_idle",     32'(dut.dstate), 32'(D_IDLE));
        chk("mrst_noack",    32'(dma_ack),    32'(0));
        tick;
        dma_req = 1'b1;
        @(negedge ph1);
        chk("mrst_reissue",  32'(mem_en), 32'(1));
        tick;
        tick;
        @(negedge ph1);
        chk("mrst_ack3",     32'(dma_ack),   32'(1));
        chk("mrst_rdata3",   32'(dma_rdata), 32'h7F);
        tick;
        dma_req = 1'b0;

        // MAX_STARVE=0: DMA wins at once, CPU goes during D_ISSUED.
        cpu_req0 = 1'b1; cpu_addr0 = 16'h0040;
        dma_req0 = 1'b1; dma_addr0 = 16'h0050;
        @(negedge ph1);
        chk("ms0_cpu_stall", 32'(cpu_ready0), 32'(0));
        chk("ms0_mem_en",    32'(mem_en0),    32'(1));
        chk("ms0_dma_addr",  32'(mem_addr0),  32'h0050);
        tick;
        @(negedge ph1);
        chk("ms0_cpu_go",    32'(cpu_ready0), 32'(1));
        chk("ms0_cpu_addr",  32'(mem_addr0),  32'h0040);
        chk("ms0_owner",     32'(dma_owner0), 32'(1));
        tick;
        @(negedge ph1);
        chk("ms0_ack",       32'(dma_ack0),   32'(1));
        chk("ms0_cpu_w_ack", 32'(cpu_ready0), 32'(1));
        tick;
        cpu_req0 = 1'b0; dma_req0 = 1'b0;
        @(negedge ph1);
        chk("ms0_idle",      32'(mem_en0), 32'(0));
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
